// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM states, bridge read-type codes and default geometry.
package icache_dm_pkg;

  localparam int DEF_LINE_NUM   = 16;
  localparam int DEF_LINE_WORDS = 4;

  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MISS   = 3'd2,
    ST_REFILL = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Byte address of the first word of the line containing addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
    logic [31:0] mask;
    mask = 32'(line_words * 4) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Tag/valid/data storage for the direct-mapped icache: combinational read,
// per-word write, tag write that also sets valid, and bulk valid clear.
module icache_line_ram
  import icache_dm_pkg::*;
#(
  parameter int LINE_NUM   = DEF_LINE_NUM,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W     = $clog2(LINE_NUM),
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int TAG_W     = 32 - IDX_W - OFF_W - 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic             wr_word_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             wr_tag_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_all
);

  logic [LINE_NUM-1:0]              valid_q;
  logic [LINE_NUM-1:0]              valid_d;
  logic [TAG_W-1:0]                 tag_mem  [LINE_NUM];
  logic [LINE_WORDS-1:0][31:0]      data_mem [LINE_NUM];

  // Valid-bit update: a bulk clear never coincides with a refill, but wins if it did.
  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = {LINE_NUM{1'b0}};
    end else if (wr_tag_en) begin
      valid_d[wr_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only reset storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= {LINE_NUM{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    if (wr_word_en) begin
      data_mem[wr_idx][wr_off] <= wr_data;
    end
    if (wr_tag_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

  // Asynchronous read port.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_mem[rd_idx];
    rd_word  = data_mem[rd_idx][rd_off];
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, blocking instruction cache between the IF stage and the
// AXI read bridge; uncached fetches go straight to the bridge as single words.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINE_NUM   = DEF_LINE_NUM,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  input  logic        inst_uncached,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        inv_valid,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             unc_q, unc_d;
  logic             inv_pend_q, inv_pend_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] idx_s;
  logic [OFF_W-1:0] off_s;
  logic [TAG_W-1:0] tag_s;
  logic             ram_valid_s;
  logic [TAG_W-1:0] ram_tag_s;
  logic [31:0]      ram_word_s;
  logic             hit_s;
  logic             accept_s;
  logic             wr_word_en_s;
  logic             wr_tag_en_s;
  logic             clr_all_s;

  assign idx_s = addr_q[2+OFF_W +: IDX_W];
  assign off_s = addr_q[2 +: OFF_W];
  assign tag_s = addr_q[31 -: TAG_W];

  icache_line_ram #(
    .LINE_NUM   (LINE_NUM),
    .LINE_WORDS (LINE_WORDS)
  ) u_ram (
    .clk        (clk),
    .resetn     (resetn),
    .rd_idx     (idx_s),
    .rd_off     (off_s),
    .rd_valid   (ram_valid_s),
    .rd_tag     (ram_tag_s),
    .rd_word    (ram_word_s),
    .wr_word_en (wr_word_en_s),
    .wr_idx     (idx_s),
    .wr_off     (cnt_q),
    .wr_data    (ret_data),
    .wr_tag_en  (wr_tag_en_s),
    .wr_tag     (tag_s),
    .clr_all    (clr_all_s)
  );

  // Hit/accept decode; reset also masks acceptance so addr_ok reads 0 while held.
  always_comb begin
    hit_s    = (state_q == ST_LOOKUP) & ram_valid_s & (ram_tag_s == tag_s) & ~unc_q;
    accept_s = resetn & inst_sram_req & ~inv_valid & ~inv_pend_q &
               ((state_q == ST_IDLE) | hit_s);
  end

  // Next-state, bridge request and response datapath.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    unc_d             = unc_q;
    inv_pend_d        = inv_pend_q;
    cnt_d             = cnt_q;
    word_d            = word_q;
    rdata_d           = rdata_q;
    inst_sram_addr_ok = accept_s;
    inst_sram_data_ok = 1'b0;
    rd_req            = 1'b0;
    rd_type           = RD_TYPE_LINE;
    rd_addr           = 32'h0000_0000;
    wr_word_en_s      = 1'b0;
    wr_tag_en_s       = 1'b0;
    clr_all_s         = 1'b0;

    if (accept_s) begin
      addr_d = inst_sram_addr;
      unc_d  = inst_uncached;
    end else begin
      addr_d = addr_q;
    end

    // Invalidations seen mid-transaction wait for IDLE so the fill in flight
    // still completes, and then also clear the line it just wrote.
    if (state_q == ST_IDLE) begin
      clr_all_s  = inv_valid | inv_pend_q;
      inv_pend_d = 1'b0;
    end else if (inv_valid) begin
      inv_pend_d = 1'b1;
    end else begin
      inv_pend_d = inv_pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = accept_s ? ST_LOOKUP : ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          inst_sram_data_ok = 1'b1;
          rdata_d           = ram_word_s;
          state_d           = accept_s ? ST_LOOKUP : ST_IDLE;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        rd_req  = 1'b1;
        rd_type = unc_q ? RD_TYPE_WORD : RD_TYPE_LINE;
        rd_addr = unc_q ? addr_q : line_base(addr_q, LINE_WORDS);
        state_d = rd_rdy ? ST_REFILL : ST_MISS;
      end
      ST_REFILL: begin
        if (ret_valid) begin
          if (unc_q) begin
            word_d = ret_data;
          end else begin
            wr_word_en_s = 1'b1;
            word_d       = (cnt_q == off_s) ? ret_data : word_q;
          end
          if (ret_last) begin
            cnt_d       = {OFF_W{1'b0}};
            wr_tag_en_s = ~unc_q;
            state_d     = ST_RESP;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESP: begin
        inst_sram_data_ok = 1'b1;
        rdata_d           = word_q;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inst_sram_rdata = rdata_d;
  end

  // Control and context registers; reset abandons any miss in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      unc_q      <= 1'b0;
      inv_pend_q <= 1'b0;
      cnt_q      <= {OFF_W{1'b0}};
      word_q     <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      unc_q      <= unc_d;
      inv_pend_q <= inv_pend_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus a randomized
// fetch stream checked against a line-level cache/memory reference model.
module tb_icache_dm;

  logic        clk;
  logic        resetn;
  logic        req;
  logic [31:0] addr;
  logic        unc;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        inv_valid;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int vectors;
  int miscompares;

  // Reference cache contents: which memory line each index currently holds.
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  icache_dm dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (req),
    .inst_sram_addr    (addr),
    .inst_uncached     (unc),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .inv_valid         (inv_valid),
    .rd_req            (rd_req),
    .rd_type           (rd_type),
    .rd_addr           (rd_addr),
    .rd_rdy            (rd_rdy),
    .ret_valid         (ret_valid),
    .ret_last          (ret_last),
    .ret_data          (ret_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:4] == 28'h1c0_0000) return 32'h0000_00A0 + 32'(a[3:2]);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic bit m_hit(input logic [31:0] a, input logic u);
    return !u && m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  // Issues one fetch and acts as the bridge. stop_beat >= 0 returns control
  // inside REFILL just before that beat would be delivered.
  task automatic fetch(input logic [31:0] a, input logic u, input int inv_beat, input int stop_beat,
                       output logic missed, output logic [2:0] otype, output logic [31:0] oaddr,
                       output logic [31:0] odata, output int lat);
    int cyc, beat, nbeats;
    bit filling, got, stopped;
    logic [31:0] base;
    missed = 1'b0; otype = 3'b000; oaddr = 32'h0; odata = 32'h0; lat = 0;
    cyc = 0; beat = 0; nbeats = 0; filling = 1'b0; got = 1'b0; stopped = 1'b0; base = 32'h0;
    @(negedge clk);
    req = 1'b1; addr = a; unc = u;
    #1;
    while (addr_ok !== 1'b1 && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    vectors++;
    if (addr_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout addr=%h addr_ok=%b expected 1", a, addr_ok);
      req = 1'b0;
      return;
    end
    @(negedge clk);
    req = 1'b0;
    #1;
    lat = 1; cyc = 0;
    while (cyc < 300) begin
      if (data_ok === 1'b1) begin
        got = 1'b1; odata = rdata;
        break;
      end
      if (rd_req === 1'b1 && !filling) begin
        missed = 1'b1; otype = rd_type; oaddr = rd_addr;
        rd_rdy = 1'($urandom_range(0, 1));
        if (rd_rdy) begin
          filling = 1'b1; base = rd_addr;
          nbeats = (rd_type == 3'b100) ? 4 : 1;
        end
      end else if (filling && beat < nbeats) begin
        if (beat == stop_beat) begin
          stopped = 1'b1;
          break;
        end
        if ($urandom_range(0, 3) != 0) begin
          ret_valid = 1'b1;
          ret_data  = mem_rd(base + 32'(4 * beat));
          ret_last  = (beat == nbeats - 1);
          inv_valid = (beat == inv_beat);
          beat++;
        end
      end
      @(negedge clk);
      rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; inv_valid = 1'b0; ret_data = 32'h0;
      #1;
      lat++; cyc++;
    end
    vectors++;
    if ((stop_beat < 0) ? !got : !stopped) begin
      miscompares++;
      $display("FAIL fetch_timeout addr=%h got_data=%b reached_stop=%b", a, got, stopped);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b1; addr = 32'h1c00_0000; unc = 1'b0; inv_valid = 1'b0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    #12;
    vectors += 4;
    if (addr_ok !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ok got %b expected 0", addr_ok); end
    if (data_ok !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok got %b expected 0", data_ok); end
    if (rd_req !== 1'b0)  begin miscompares++; $display("FAIL reset_rd_req got %b expected 0", rd_req); end
    if (rdata !== 32'h0)  begin miscompares++; $display("FAIL reset_rdata got %h expected 0", rdata); end
    @(negedge clk);
    resetn = 1'b1; req = 1'b0;
  endtask

  task automatic test_cold_fill();
    logic m; logic [2:0] t; logic [31:0] ra, d; int lat;
    fetch(32'h1c00_0000, 1'b0, -1, -1, m, t, ra, d, lat);
    vectors += 4;
    if (m !== 1'b1)            begin miscompares++; $display("FAIL cold_miss got %b expected 1", m); end
    if (t !== 3'b100)          begin miscompares++; $display("FAIL cold_rd_type got %b expected 100", t); end
    if (ra !== 32'h1c00_0000)  begin miscompares++; $display("FAIL cold_rd_addr got %h expected 1c000000", ra); end
    if (d !== 32'h0000_00A0)   begin miscompares++; $display("FAIL cold_data got %h expected a0", d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req = 1'b1; addr = 32'h1c00_0004; unc = 1'b0;
    #1;
    vectors++;
    if (addr_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_first_accept got %b expected 1", addr_ok); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) addr = 32'h1c00_0004 + 32'(4 * i);
      else req = 1'b0;
      #1;
      vectors++;
      if (data_ok !== 1'b1 || rdata !== 32'h0000_00A0 + 32'(i) || rd_req !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hit%0d data_ok=%b rdata=%h rd_req=%b expected 1/%h/0",
                 i, data_ok, rdata, rd_req, 32'h0000_00A0 + 32'(i));
      end
      if (i < 3) begin
        vectors++;
        if (addr_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_accept%0d got %b expected 1", i, addr_ok); end
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (data_ok !== 1'b0 || rdata !== 32'h0000_00A3) begin
      miscompares++;
      $display("FAIL b2b_hold data_ok=%b rdata=%h expected 0/a3", data_ok, rdata);
    end
  endtask

  task automatic test_conflict();
    logic m; logic [2:0] t; logic [31:0] ra, d; int lat;
    fetch(32'h1c00_010c, 1'b0, -1, -1, m, t, ra, d, lat);
    vectors += 3;
    if (m !== 1'b1)                  begin miscompares++; $display("FAIL conflict_miss got %b expected 1", m); end
    if (ra !== 32'h1c00_0100)        begin miscompares++; $display("FAIL conflict_rd_addr got %h expected 1c000100", ra); end
    if (d !== mem_rd(32'h1c00_010c)) begin miscompares++; $display("FAIL conflict_data got %h expected %h", d, mem_rd(32'h1c00_010c)); end
    fetch(32'h1c00_0000, 1'b0, -1, -1, m, t, ra, d, lat);
    vectors += 2;
    if (m !== 1'b1)          begin miscompares++; $display("FAIL evicted_miss got %b expected 1", m); end
    if (d !== 32'h0000_00A0) begin miscompares++; $display("FAIL evicted_data got %h expected a0", d); end
  endtask

  task automatic test_uncached();
    logic m; logic [2:0] t; logic [31:0] ra, d; int lat;
    for (int k = 0; k < 2; k++) begin
      fetch(32'hbfc0_0008, 1'b1, -1, -1, m, t, ra, d, lat);
      vectors += 4;
      if (m !== 1'b1)           begin miscompares++; $display("FAIL unc_miss%0d got %b expected 1", k, m); end
      if (t !== 3'b010)         begin miscompares++; $display("FAIL unc_rd_type%0d got %b expected 010", k, t); end
      if (ra !== 32'hbfc0_0008) begin miscompares++; $display("FAIL unc_rd_addr%0d got %h expected bfc00008", k, ra); end
      if (d !== mem_rd(32'hbfc0_0008)) begin miscompares++; $display("FAIL unc_data%0d got %h expected %h", k, d, mem_rd(32'hbfc0_0008)); end
    end
  endtask

  task automatic test_invalidate();
    logic m; logic [2:0] t; logic [31:0] ra, d; int lat;
    fetch(32'h1c00_0024, 1'b0, 2, -1, m, t, ra, d, lat);
    vectors++;
    if (d !== mem_rd(32'h1c00_0024)) begin miscompares++; $display("FAIL inv_fill_data got %h expected %h", d, mem_rd(32'h1c00_0024)); end
    fetch(32'h1c00_0024, 1'b0, -1, -1, m, t, ra, d, lat);
    vectors++;
    if (m !== 1'b1) begin miscompares++; $display("FAIL inv_refetch_miss got %b expected 1", m); end
    @(negedge clk);
    req = 1'b1; addr = 32'h1c00_0024; unc = 1'b0; inv_valid = 1'b1;
    #1;
    vectors++;
    if (addr_ok !== 1'b0) begin miscompares++; $display("FAIL inv_priority addr_ok=%b expected 0", addr_ok); end
    @(negedge clk);
    req = 1'b0; inv_valid = 1'b0;
    fetch(32'h1c00_0024, 1'b0, -1, -1, m, t, ra, d, lat);
    vectors++;
    if (m !== 1'b1) begin miscompares++; $display("FAIL inv_idle_miss got %b expected 1", m); end
  endtask

  task automatic test_reset_refill();
    logic m; logic [2:0] t; logic [31:0] ra, d; int lat;
    fetch(32'h1c00_0038, 1'b0, -1, 2, m, t, ra, d, lat);
    resetn = 1'b0; ret_valid = 1'b1; ret_data = mem_rd(32'h1c00_0038);
    #1;
    vectors++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rd_req !== 1'b0 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_refill_outputs addr_ok=%b data_ok=%b rd_req=%b rdata=%h expected all 0",
               addr_ok, data_ok, rd_req, rdata);
    end
    @(negedge clk);
    resetn = 1'b1; ret_valid = 1'b1; ret_last = 1'b1; ret_data = mem_rd(32'h1c00_003c);
    @(negedge clk);
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    #1;
    vectors++;
    if (data_ok !== 1'b0 || rd_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stray_beat data_ok=%b rd_req=%b expected 0/0", data_ok, rd_req);
    end
    fetch(32'h1c00_0038, 1'b0, -1, -1, m, t, ra, d, lat);
    vectors += 2;
    if (m !== 1'b1) begin miscompares++; $display("FAIL rst_refetch_miss got %b expected 1", m); end
    if (d !== mem_rd(32'h1c00_0038)) begin miscompares++; $display("FAIL rst_refetch_data got %h expected %h", d, mem_rd(32'h1c00_0038)); end
  endtask

  task automatic test_random();
    logic m; logic [2:0] t; logic [31:0] ra, d, a; int lat, ib;
    logic u; bit exp_miss;
    logic [23:0] tags [4];
    tags[0] = 24'h1c0000; tags[1] = 24'h1c0001; tags[2] = 24'h1c0002; tags[3] = 24'h800003;
    @(negedge clk); inv_valid = 1'b1;
    @(negedge clk); inv_valid = 1'b0;
    m_clear();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(negedge clk); inv_valid = 1'b1;
        @(negedge clk); inv_valid = 1'b0;
        m_clear();
        continue;
      end
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      u = ($urandom_range(0, 7) == 0);
      exp_miss = !m_hit(a, u);
      ib = (exp_miss && !u && $urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      fetch(a, u, ib, -1, m, t, ra, d, lat);
      vectors += 2;
      if (m !== exp_miss) begin miscompares++; $display("FAIL rnd_miss addr=%h unc=%b got %b expected %b", a, u, m, exp_miss); end
      if (d !== mem_rd(a)) begin miscompares++; $display("FAIL rnd_data addr=%h got %h expected %h", a, d, mem_rd(a)); end
      if (exp_miss) begin
        vectors++;
        if (t !== (u ? 3'b010 : 3'b100) || ra !== (u ? a : {a[31:4], 4'h0})) begin
          miscompares++;
          $display("FAIL rnd_rd_req addr=%h got type %b addr %h", a, t, ra);
        end
        if (!u) begin
          m_valid[a[7:4]] = 1'b1;
          m_tag[a[7:4]]   = a[31:8];
        end
        if (ib >= 0) m_clear();
      end else begin
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL rnd_hit_latency addr=%h got %0d expected 1", a, lat); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_cold_fill();
    test_back_to_back();
    test_conflict();
    test_uncached();
    test_invalidate();
    test_reset_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
